ahb_arbiter: RTL

Round-robin bus arbiter that shares the AHB address/data bus between up to eight AHB masters ahead of the AHB-to-APB bridge slave. It samples each master's request and lock lines, tracks fixed-length bursts beat by beat, and drives one-hot grants. It also drives the registered master-number and master-lock outputs used by the address/data multiplexers and the bridge. Grant changes only at transfer boundaries that the AHB protocol allows.

---
 rtl/ahb_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter for up to eight masters. It tracks fixed-length and INCR bursts
// so that the grant moves only at legal transfer boundaries.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic                   Hreadyout,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [3:0]             Hmaster,
    output logic                   Hmastlock
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [4:0]       beats;
    logic [4:0]       beats_next;
    logic             incr_act;
    logic             incr_next;
    logic             rearb;

    function automatic logic [4:0] burst_last(input logic [2:0] burst);
        case (burst)
            3'd0, 3'd1: burst_last = 5'd0;
            3'd2, 3'd3: burst_last = 5'd3;
            3'd4, 3'd5: burst_last = 5'd7;
            default:    burst_last = 5'd15;
        endcase
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUM_MASTERS'(1) << idx;
    endfunction

    // Beat counter and INCR tracking as they will stand after this edge
    always_comb begin
        beats_next = beats;
        incr_next  = incr_act;
        case (Htrans)
            TR_NONSEQ: begin
                beats_next = burst_last(Hburst);
                incr_next  = (Hburst == 3'd1);
            end
            TR_SEQ: begin
                if (beats != 5'd0) beats_next = beats - 5'd1;
            end
            TR_BUSY: begin
                beats_next = beats;
            end
            default: begin
                beats_next = 5'd0;
                incr_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        rearb = !(Hlock[owner] && Hbusreq[owner])
              && (beats_next == 5'd0)
              && !(incr_next && Hbusreq[owner] && (Htrans != TR_IDLE));
    end

    // Rotating search: the current owner is visited last, so it has the lowest priority
    always_comb begin
        winner = owner;
        found  = 1'b0;
        cand   = owner;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_W'((int'(owner) + i) % NUM_MASTERS);
            if (!found && Hbusreq[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        if (!found) winner = DEF_IDX;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            owner     <= DEF_IDX;
            Hgrant    <= onehot(DEF_IDX);
            beats     <= 5'd0;
            incr_act  <= 1'b0;
            Hmaster   <= 4'(DEF_IDX);
            Hmastlock <= 1'b0;
        end else if (Hreadyout) begin
            beats     <= beats_next;
            incr_act  <= incr_next;
            Hmaster   <= 4'(owner);
            Hmastlock <= Hlock[owner];
            if (rearb) begin
                owner  <= winner;
                Hgrant <= onehot(winner);
            end
        end
    end

endmodule
